bcd_timer_ctrl: RTL

Parametrised successor to the four-digit MM:SS countdown controller. It drives N BCD digits with a per-digit modulus and supports count-down and count-up-to-target modes. Auto-reload makes it a repeating interval timer. It sits between the board I/O (debounced pulse buttons, switches, an external 1 Hz strobe) and the 7-segment and LED decoders.

---
 rtl/timer_pkg.sv | 20 ++
 rtl/bcd_digit_cell.sv | 44 ++++
 rtl/bcd_timer_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the BCD interval timer: state encoding, digit width
// and a helper that pulls one digit's modulus-1 out of the packed DIGIT_MAX.
package timer_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SET  = 3'd1,
        ST_STOP = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Largest legal value of digit i (4 bits per digit, digit 0 in the LSBs).
    function automatic logic [DIGIT_W-1:0] digit_max(input logic [31:0] dmax, input int i);
        return dmax[i*DIGIT_W +: DIGIT_W];
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit with its own modulus. Steps up or down when enabled, wraps at
// 0 / max, and flags the wrap on o_chain so the next digit can ripple.
module bcd_digit_cell
    import timer_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_step_en,
    input  logic               i_dir,       // 1 = up, 0 = down
    input  logic [DIGIT_W-1:0] i_max,
    input  logic               i_load_en,   // wins over stepping
    input  logic [DIGIT_W-1:0] i_load_val,
    output logic [DIGIT_W-1:0] o_value,
    output logic [DIGIT_W-1:0] o_step_val,  // value this cell takes if it steps now
    output logic               o_chain
);

    logic [DIGIT_W-1:0] r_value;
    logic [DIGIT_W-1:0] w_step_val;
    logic               w_wrap;

    assign w_wrap  = i_dir ? (r_value == i_max) : (r_value == '0);
    assign o_chain = i_step_en & w_wrap;

    // Post-step value; exposed so the top can detect terminal count before the edge.
    always_comb begin
        w_step_val = r_value;
        if (i_step_en) begin
            if (i_dir) w_step_val = w_wrap ? '0 : r_value + 4'd1;
            else       w_step_val = w_wrap ? i_max : r_value - 4'd1;
        end
    end

    // Digit register: load overrides step.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)        r_value <= '0;
        else if (i_load_en) r_value <= i_load_val;
        else                r_value <= w_step_val;
    end

    assign o_value    = r_value;
    assign o_step_val = w_step_val;

endmodule

// File: rtl/bcd_timer_ctrl.sv
// N-digit BCD countdown / count-up-to-target timer with optional auto-reload.
// Pairs of digits are entered from switches in SET, then the block runs on an
// external 1 Hz strobe until the terminal count.
module bcd_timer_ctrl
    import timer_pkg::*;
#(
    parameter int          NUM_DIGITS = 4,
    parameter logic [31:0] DIGIT_MAX  = 32'h0000_9959
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_tick,
    input  logic                            i_start_stop,
    input  logic                            i_set,
    input  logic                            i_clear,
    input  logic                            i_count_up,
    input  logic                            i_reload_en,
    input  logic [7:0]                      i_sw_value,
    output logic [DIGIT_W*NUM_DIGITS-1:0]   o_digits,
    output logic [2:0]                      o_state,
    output logic [$clog2(NUM_DIGITS/2):0]   o_set_pair,
    output logic                            o_running,
    output logic                            o_done,
    output logic                            o_done_pulse
);

    localparam int PAIRS = NUM_DIGITS / 2;
    localparam int PW    = $clog2(PAIRS) + 1;
    localparam int DW    = DIGIT_W * NUM_DIGITS;
    localparam logic [PW-1:0] LAST_PAIR = PW'(PAIRS - 1);

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_set_pair, w_set_pair_nxt;
    logic [DW-1:0]   r_load, w_load_nxt;
    logic [DW-1:0]   r_preset, w_preset_nxt;
    logic            r_mode, w_mode_nxt;          // 1 = count up
    logic            r_done_pulse, w_done_pulse_nxt;

    logic [DW-1:0]   w_clamp;                     // clamped sw_value placed at every pair slot
    logic [DW-1:0]   w_load_upd;                  // load register with current pair replaced
    logic [DW-1:0]   w_digits, w_step_digits;
    logic [DW-1:0]   w_target, w_reload_val;
    logic [DW-1:0]   w_cell_load_val;
    logic            w_cell_load_en;
    logic            w_step_req;
    logic [NUM_DIGITS-1:0] w_chain;
    logic            w_step_hit, w_at_target;
    logic            w_unused_top_wrap;

    assign w_unused_top_wrap = w_chain[NUM_DIGITS-1];

    // Clamp each switch nibble to the modulus-1 of the digit it lands on.
    for (genvar gp = 0; gp < PAIRS; gp++) begin : g_pair
        localparam logic [DIGIT_W-1:0] MAX_ONES = digit_max(DIGIT_MAX, 2*gp);
        localparam logic [DIGIT_W-1:0] MAX_TENS = digit_max(DIGIT_MAX, 2*gp + 1);
        assign w_clamp[gp*8 +: 8] = {
            (i_sw_value[7:4] > MAX_TENS) ? MAX_TENS : i_sw_value[7:4],
            (i_sw_value[3:0] > MAX_ONES) ? MAX_ONES : i_sw_value[3:0]
        };
    end

    // Load register image with the pair under edit replaced by the live switches.
    always_comb begin
        w_load_upd = r_load;
        for (int p = 0; p < PAIRS; p++) begin
            if (r_set_pair == PW'(p)) w_load_upd[p*8 +: 8] = w_clamp[p*8 +: 8];
        end
    end

    // Digit chain: each digit steps only when every lower digit wrapped.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        logic w_en;
        if (gi == 0) begin : g_first
            assign w_en = w_step_req;
        end else begin : g_rest
            assign w_en = w_chain[gi-1];
        end
        bcd_digit_cell u_cell (
            .i_clk      (i_clk),
            .i_reset    (i_reset),
            .i_step_en  (w_en),
            .i_dir      (r_mode),
            .i_max      (digit_max(DIGIT_MAX, gi)),
            .i_load_en  (w_cell_load_en),
            .i_load_val (w_cell_load_val[gi*DIGIT_W +: DIGIT_W]),
            .o_value    (w_digits[gi*DIGIT_W +: DIGIT_W]),
            .o_step_val (w_step_digits[gi*DIGIT_W +: DIGIT_W]),
            .o_chain    (w_chain[gi])
        );
    end

    assign w_target     = r_mode ? r_preset : '0;
    assign w_reload_val = r_mode ? '0 : r_preset;
    assign w_step_hit   = (w_step_digits == w_target);
    assign w_at_target  = (w_digits == w_target);

    // Next-state, register updates and digit load/step control.
    always_comb begin
        w_state_nxt      = r_state;
        w_set_pair_nxt   = r_set_pair;
        w_load_nxt       = r_load;
        w_preset_nxt     = r_preset;
        w_mode_nxt       = r_mode;
        w_done_pulse_nxt = 1'b0;
        w_cell_load_en   = 1'b0;
        w_cell_load_val  = w_reload_val;
        w_step_req       = 1'b0;

        if (i_clear) begin
            w_state_nxt     = ST_IDLE;
            w_set_pair_nxt  = '0;
            w_load_nxt      = '0;
            w_preset_nxt    = '0;
            w_mode_nxt      = 1'b0;
            w_cell_load_en  = 1'b1;
            w_cell_load_val = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_set) begin
                        w_state_nxt    = ST_SET;
                        w_set_pair_nxt = '0;
                    end
                end
                ST_SET: begin
                    w_load_nxt = w_load_upd;
                    if (i_set) begin
                        if (r_set_pair == LAST_PAIR) begin
                            // Commit uses this cycle's switches, not last cycle's register.
                            w_state_nxt     = ST_STOP;
                            w_set_pair_nxt  = '0;
                            w_preset_nxt    = w_load_upd;
                            w_mode_nxt      = i_count_up;
                            w_cell_load_en  = 1'b1;
                            w_cell_load_val = i_count_up ? '0 : w_load_upd;
                        end else begin
                            w_set_pair_nxt = r_set_pair + PW'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (i_set) begin
                        w_state_nxt    = ST_SET;
                        w_set_pair_nxt = '0;
                    end else if (i_start_stop) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (i_tick) begin
                        w_step_req = 1'b1;
                        if (w_step_hit) begin
                            w_done_pulse_nxt = 1'b1;
                            if (i_reload_en) begin
                                w_cell_load_en = 1'b1;
                                w_state_nxt    = i_start_stop ? ST_STOP : ST_RUN;
                            end else begin
                                // Stepped value already equals target; DONE beats STOP.
                                w_state_nxt = ST_DONE;
                            end
                        end else if (i_start_stop) begin
                            w_state_nxt = ST_STOP;
                        end
                    end else if (w_at_target && !i_reload_en) begin
                        // Zero-length run: finish without waiting for a tick.
                        w_state_nxt      = ST_DONE;
                        w_done_pulse_nxt = 1'b1;
                    end else if (i_start_stop) begin
                        w_state_nxt = ST_STOP;
                    end
                end
                ST_DONE: begin
                    if (i_set) begin
                        w_state_nxt    = ST_SET;
                        w_set_pair_nxt = '0;
                    end else if (i_start_stop) begin
                        w_state_nxt    = ST_STOP;
                        w_cell_load_en = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Control registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_set_pair   <= '0;
            r_load       <= '0;
            r_preset     <= '0;
            r_mode       <= 1'b0;
            r_done_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_set_pair   <= w_set_pair_nxt;
            r_load       <= w_load_nxt;
            r_preset     <= w_preset_nxt;
            r_mode       <= w_mode_nxt;
            r_done_pulse <= w_done_pulse_nxt;
        end
    end

    assign o_digits     = w_digits;
    assign o_state      = r_state;
    assign o_set_pair   = r_set_pair;
    assign o_running    = (r_state == ST_RUN);
    assign o_done       = (r_state == ST_DONE);
    assign o_done_pulse = r_done_pulse;

endmodule
